// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each write is a single-cycle strobe, followed by an ack/err wait and a per-requester done/err pulse.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            err,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_wr_err,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          busy,
  output logic                          stall,
  output logic [15:0]                   wr_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IW-1:0]           r_rr_ptr;
  logic [IW-1:0]           r_winner;
  logic [CW-1:0]           r_tcnt;
  logic [CW-1:0]           w_tcnt_nxt;
  logic                    r_fifo_wr;
  logic [DATA_WIDTH-1:0]   r_fifo_din;
  logic [NUM_REQ-1:0]      r_done;
  logic [NUM_REQ-1:0]      r_err;
  logic [15:0]             r_wr_count;
  logic [IW:0]             w_idx;
  logic [IW-1:0]           w_winner;
  logic [DATA_WIDTH-1:0]   w_win_data;
  logic                    w_timeout;
  logic                    w_issue;
  logic                    w_fin;
  logic                    w_fin_err;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] cur);
    if (cur == IW'(NUM_REQ - 1)) return '0;
    return cur + IW'(1);
  endfunction

  // Highest-priority requester is the first set bit at or after rr_ptr, wrapping.
  // Scanning from the far end lets the nearest candidate overwrite the others.
  always_comb begin
    w_idx    = '0;
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NUM_REQ)) w_idx = w_idx - (IW+1)'(NUM_REQ);
      if (req[w_idx[IW-1:0]]) w_winner = w_idx[IW-1:0];
    end
  end

  assign w_win_data = req_data[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
  assign w_tcnt_nxt = r_tcnt + CW'(1);
  assign w_timeout  = (w_tcnt_nxt == CW'(ACK_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_fin       = 1'b0;
    w_fin_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req && !fifo_full) begin
          w_state_nxt = ISSUE;
          w_issue     = 1'b1;
        end
      end
      ISSUE: begin
        if (fifo_wr_ack || fifo_wr_err) begin
          w_state_nxt = DONE;
          w_fin       = 1'b1;
          w_fin_err   = fifo_wr_err;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A real response in the final WAIT cycle takes precedence over the timeout.
        if (fifo_wr_ack || fifo_wr_err) begin
          w_state_nxt = DONE;
          w_fin       = 1'b1;
          w_fin_err   = fifo_wr_err;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
          w_fin       = 1'b1;
          w_fin_err   = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fifo_wr  <= 1'b0;
      r_fifo_din <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_wr_count <= '0;
      r_rr_ptr   <= '0;
      r_winner   <= '0;
      r_tcnt     <= '0;
    end else begin
      r_fifo_wr <= w_issue;
      r_done    <= '0;
      r_err     <= '0;
      if (w_issue) begin
        r_winner   <= w_winner;
        r_fifo_din <= w_win_data;
        r_tcnt     <= '0;
      end
      if (r_state == WAIT) r_tcnt <= w_tcnt_nxt;
      // Response pulses are registered so they appear during the DONE state.
      if (w_fin) begin
        if (w_fin_err) begin
          r_err <= NUM_REQ'(1) << r_winner;
        end else begin
          r_done     <= NUM_REQ'(1) << r_winner;
          r_wr_count <= r_wr_count + 16'd1;
        end
        r_rr_ptr <= rr_next(r_winner);
      end
    end
  end

  assign fifo_wr  = r_fifo_wr;
  assign fifo_din = r_fifo_din;
  assign done     = r_done;
  assign err      = r_err;
  assign wr_count = r_wr_count;
  assign busy     = (r_state != IDLE);
  assign stall    = (r_state == IDLE) && (|req) && fifo_full;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario bench for fifo_wr_arbiter: tasks drive requests and push expected writes,
// a negedge monitor pops them as strobes and response pulses appear.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  done;
  logic [3:0]  err;
  logic        fifo_full;
  logic        fifo_wr_ack;
  logic        fifo_wr_err;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic        busy;
  logic        stall;
  logic [15:0] wr_count;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .done(done), .err(err), .fifo_full(fifo_full),
    .fifo_wr_ack(fifo_wr_ack), .fifo_wr_err(fifo_wr_err),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .busy(busy), .stall(stall),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       is_err;
  } exp_t;

  exp_t q_wr[$];
  exp_t q_rs[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_wr = -100;
  int   rmode   = 0;
  logic prev_wr = 1'b0;
  int   exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe must match the next queued write, every pulse the next response.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] ed, ee;
    if (rst_n === 1'b1 && fifo_wr === 1'b1) begin
      n_tests++;
      if (cyc - last_wr < 3) begin
        n_fail++;
        $display("FAIL sb_wr_spacing: gap %0d cycles, required >= 3", cyc - last_wr);
      end
      last_wr = cyc;
      if (q_wr.size() == 0) begin
        n_fail++;
        $display("FAIL sb_wr_unexpected: fifo_din=%h, no write expected", fifo_din);
      end else begin
        e = q_wr.pop_front();
        q_rs.push_back(e);
        n_tests++;
        if (fifo_din !== e.data) begin
          n_fail++;
          $display("FAIL sb_wr_data: fifo_din=%h required %h", fifo_din, e.data);
        end
      end
    end
    if (done !== 4'b0 || err !== 4'b0) begin
      n_tests++;
      if (q_rs.size() == 0) begin
        n_fail++;
        $display("FAIL sb_rsp_unexpected: done=%b err=%b, none expected", done, err);
      end else begin
        e  = q_rs.pop_front();
        ed = e.is_err ? 4'b0 : (4'b1 << e.id);
        ee = e.is_err ? (4'b1 << e.id) : 4'b0;
        if (done !== ed || err !== ee) begin
          n_fail++;
          $display("FAIL sb_rsp: done=%b err=%b required done=%b err=%b", done, err, ed, ee);
        end
      end
    end
  end

  // Advances to the next negedge and plays the FIFO side of the handshake.
  task automatic tick();
    @(negedge clk);
    case (rmode)
      0:       begin fifo_wr_ack = fifo_wr; fifo_wr_err = 1'b0;    end
      2:       begin fifo_wr_ack = prev_wr; fifo_wr_err = prev_wr; end
      default: begin fifo_wr_ack = 1'b0;    fifo_wr_err = 1'b0;    end
    endcase
    prev_wr = fifo_wr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0; req_data = $urandom; fifo_full = 1'b0;
    fifo_wr_ack = 1'b0; fifo_wr_err = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({fifo_wr, fifo_din, done, err, busy, stall} !== 19'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: wr=%b din=%h done=%b err=%b busy=%b stall=%b, required all 0",
               fifo_wr, fifo_din, done, err, busy, stall);
    end
    n_tests++;
    if (wr_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count: wr_count=%0d required 0", wr_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    rmode = 0;
    q_wr.push_back('{0, 8'hA5, 1'b0});
    req = 4'b0001; req_data = {8'h11, 8'h22, 8'h33, 8'hA5};
    tick();
    n_tests++;
    if (fifo_wr !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_strobe: fifo_wr=%b busy=%b at N+1, required 1 1", fifo_wr, busy);
    end
    req = 4'b0; req_data = 32'hFFFF_FFFF;
    tick();
    n_tests++;
    if (done !== 4'b0001 || fifo_din !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_done: done=%b din=%h at N+2, required 0001 a5", done, fifo_din);
    end
    tick();
    exp_cnt = 1;
    n_tests++;
    if (busy !== 1'b0 || wr_count !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b wr_count=%0d at N+3, required 0 %0d", busy, wr_count, exp_cnt);
    end
  endtask

  task automatic test_round_robin();
    int wr_cyc[$];
    int ndone = 0;
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    exp_cnt = 0;
    rmode = 0;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int i = 0; i < 5; i++) q_wr.push_back('{i % 4, 8'h10 + 8'(i % 4) * 8'h11, 1'b0});
    req = 4'b1111;
    for (int i = 0; i < 40 && ndone < 5; i++) begin
      tick();
      if (fifo_wr === 1'b1) wr_cyc.push_back(cyc);
      if (done !== 4'b0) ndone++;
      if (ndone == 5) req = 4'b0;
    end
    exp_cnt = 5;
    n_tests++;
    if (ndone != 5) begin
      n_fail++;
      $display("FAIL rr_budget: %0d dones seen, required 5", ndone);
    end
    n_tests++;
    if (wr_count !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL rr_count: wr_count=%0d required %0d", wr_count, exp_cnt);
    end
    for (int i = 1; i < wr_cyc.size(); i++) begin
      n_tests++;
      if (wr_cyc[i] - wr_cyc[i-1] != 3) begin
        n_fail++;
        $display("FAIL rr_spacing: gap %0d cycles, required 3", wr_cyc[i] - wr_cyc[i-1]);
      end
    end
    tick();
  endtask

  task automatic test_full();
    rmode = 0;
    fifo_full = 1'b1; req = 4'b0100; req_data = {8'h00, 8'h5C, 8'h00, 8'h00};
    q_wr.push_back('{2, 8'h5C, 1'b0});
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (stall !== 1'b1 || fifo_wr !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL full_hold: stall=%b fifo_wr=%b busy=%b, required 1 0 0", stall, fifo_wr, busy);
      end
    end
    fifo_full = 1'b0;
    tick();
    n_tests++;
    if (fifo_wr !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL full_release: fifo_wr=%b stall=%b, required 1 0", fifo_wr, stall);
    end
    req = 4'b0;
    tick();
    n_tests++;
    if (done !== 4'b0100) begin
      n_fail++;
      $display("FAIL full_done: done=%b required 0100", done);
    end
    exp_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    rmode = 1;
    req = 4'b0010; req_data = {8'h00, 8'h00, 8'h77, 8'h00};
    q_wr.push_back('{1, 8'h77, 1'b1});
    tick();
    req = 4'b0;
    for (int n = 2; n <= 5; n++) begin
      tick();
      n_tests++;
      if (err !== 4'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout_wait: err=%b busy=%b at N+%0d, required 0000 1", err, busy, n);
      end
    end
    tick();
    n_tests++;
    if (err !== 4'b0010 || done !== 4'b0 || wr_count !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b done=%b wr_count=%0d at N+6, required 0010 0000 %0d",
               err, done, wr_count, exp_cnt);
    end
    tick();
    // With every requester asking, the pointer left at 2 must pick requester 2.
    rmode = 0;
    req = 4'b1111; req_data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
    q_wr.push_back('{2, 8'hE2, 1'b0});
    tick();
    req = 4'b0;
    tick();
    n_tests++;
    if (done !== 4'b0100) begin
      n_fail++;
      $display("FAIL timeout_rrptr: done=%b required 0100", done);
    end
    exp_cnt++;
    tick();
  endtask

  task automatic test_collision();
    rmode = 2;
    req = 4'b1000; req_data = {8'hC3, 8'h00, 8'h00, 8'h00};
    q_wr.push_back('{3, 8'hC3, 1'b1});
    tick();
    req = 4'b0;
    tick();
    tick();
    n_tests++;
    if (err !== 4'b1000 || done !== 4'b0) begin
      n_fail++;
      $display("FAIL collision_pulse: err=%b done=%b, required 1000 0000", err, done);
    end
    tick();
    n_tests++;
    if (wr_count !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL collision_count: wr_count=%0d required %0d", wr_count, exp_cnt);
    end
    rmode = 0;
  endtask

  task automatic test_reset_midop();
    int got = 0;
    rmode = 1;
    req = 4'b0001; req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
    q_wr.push_back('{0, 8'h3C, 1'b0});
    tick();
    req = 4'b0;
    tick();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (fifo_wr !== 1'b0 || busy !== 1'b0 || wr_count !== 16'd0 || done !== 4'b0 || err !== 4'b0) begin
      n_fail++;
      $display("FAIL midop_reset: wr=%b busy=%b cnt=%0d done=%b err=%b, required 0 0 0 0000 0000",
               fifo_wr, busy, wr_count, done, err);
    end
    q_rs.delete();
    rst_n = 1'b1;
    repeat (3) tick();
    rmode = 0;
    req = 4'b0010; req_data = {8'h00, 8'h00, 8'h99, 8'h00};
    q_wr.push_back('{1, 8'h99, 1'b0});
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (fifo_wr === 1'b1) req = 4'b0;
      if (done !== 4'b0) got = 1;
    end
    n_tests++;
    if (got != 1 || wr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL midop_recover: done_seen=%0d wr_count=%0d, required 1 1", got, wr_count);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_timeout();
    test_collision();
    test_reset_midop();
    repeat (3) tick();
    n_tests++;
    if (q_wr.size() != 0 || q_rs.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d writes and %0d responses outstanding, required 0 0", q_wr.size(), q_rs.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
